// File: rtl/rf_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter_if
// Description : Bundle of the requester handshakes, scoreboard query/reserve
//               signals and the register-file write port.
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_write_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  // pipeline writeback requester
  logic                  p0_valid;
  logic [4:0]            p0_addr;
  logic [DATA_WIDTH-1:0] p0_data;
  logic                  p0_ready;
  // long-latency unit requester
  logic                  p1_valid;
  logic [4:0]            p1_addr;
  logic [DATA_WIDTH-1:0] p1_data;
  logic                  p1_ready;
  // destination reservation at issue
  logic                  rsv_valid;
  logic [4:0]            rsv_addr;
  logic                  rsv_ready;
  // hazard queries
  logic [4:0]            q_a1;
  logic [4:0]            q_a2;
  logic                  q_busy1;
  logic                  q_busy2;
  // register file write port
  logic                  we3;
  logic [4:0]            a3;
  logic [DATA_WIDTH-1:0] wd3;

  modport master (
    output p0_valid, p0_addr, p0_data, input p0_ready,
    output p1_valid, p1_addr, p1_data, input p1_ready,
    output rsv_valid, rsv_addr, input rsv_ready,
    output q_a1, q_a2, input q_busy1, q_busy2,
    input  we3, a3, wd3
  );

  modport slave (
    input  p0_valid, p0_addr, p0_data, output p0_ready,
    input  p1_valid, p1_addr, p1_data, output p1_ready,
    input  rsv_valid, rsv_addr, output rsv_ready,
    input  q_a1, q_a2, output q_busy1, q_busy2,
    output we3, a3, wd3
  );
endinterface
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter
// Description : Shares the register file write port between the in-order
//               writeback (port 0) and a long-latency unit (port 1), and keeps
//               a pending-write scoreboard for registers owed a port-1 result.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter #(
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned NREG       = 32
) (
  input  logic              clk,
  input  logic              rst,
  rf_write_arbiter_if.slave bus
);

  localparam logic [4:0] ZERO_ADDR = 5'd0;

  // Busy lookup; register 0 is never tracked and always reads as free.
  function automatic logic busy_at(input logic [NREG-1:0] vec, input logic [4:0] addr);
    logic r;
    r = 1'b0;
    for (int i = 1; i < int'(NREG); i++) begin
      if (addr == 5'(i)) r = vec[i];
    end
    return r;
  endfunction

  logic [NREG-1:0]       busy_q,       busy_d;
  logic                  last_grant_q, last_grant_d;  // 1: port 1 was granted last
  logic                  we3_q,        we3_d;
  logic [4:0]            a3_q,         a3_d;
  logic [DATA_WIDTH-1:0] wd3_q,        wd3_d;
  logic                  clr_pend_q,   clr_pend_d;
  logic [4:0]            clr_addr_q,   clr_addr_d;

  logic p0_elig, p1_elig;
  logic grant0, grant1;
  logic rsv_ok, rsv_fire;

  // Eligibility and round-robin arbitration; nothing is granted while in reset.
  always_comb begin
    p0_elig  = bus.p0_valid &&
               (!busy_at(busy_q, bus.p0_addr) || bus.p0_addr == ZERO_ADDR);
    p1_elig  = bus.p1_valid;
    grant0   = rst && p0_elig && (!p1_elig || last_grant_q);
    grant1   = rst && p1_elig && (!p0_elig || !last_grant_q);
    rsv_ok   = rst && (!busy_at(busy_q, bus.rsv_addr) || bus.rsv_addr == ZERO_ADDR);
    rsv_fire = rsv_ok && bus.rsv_valid && (bus.rsv_addr != ZERO_ADDR);
  end

  // Next state: commit stage, grant history and scoreboard (set beats clear).
  always_comb begin
    we3_d        = 1'b0;
    a3_d         = a3_q;
    wd3_d        = wd3_q;
    last_grant_d = last_grant_q;
    clr_pend_d   = grant1;
    clr_addr_d   = clr_addr_q;
    busy_d       = busy_q;

    if (grant0) begin
      we3_d        = (bus.p0_addr != ZERO_ADDR);
      a3_d         = bus.p0_addr;
      wd3_d        = bus.p0_data;
      last_grant_d = 1'b0;
    end else if (grant1) begin
      we3_d        = (bus.p1_addr != ZERO_ADDR);
      a3_d         = bus.p1_addr;
      wd3_d        = bus.p1_data;
      last_grant_d = 1'b1;
      clr_addr_d   = bus.p1_addr;
    end

    // The clear lands on the same edge the register file takes the data.
    for (int i = 0; i < int'(NREG); i++) begin
      if (clr_pend_q && clr_addr_q == 5'(i)) busy_d[i] = 1'b0;
      if (rsv_fire && bus.rsv_addr == 5'(i)) busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q       <= '0;
      last_grant_q <= 1'b1;
      we3_q        <= 1'b0;
      a3_q         <= '0;
      wd3_q        <= '0;
      clr_pend_q   <= 1'b0;
      clr_addr_q   <= '0;
    end else begin
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
      we3_q        <= we3_d;
      a3_q         <= a3_d;
      wd3_q        <= wd3_d;
      clr_pend_q   <= clr_pend_d;
      clr_addr_q   <= clr_addr_d;
    end
  end

  // Outputs: handshake readies, hazard queries and the registered write port.
  always_comb begin
    bus.p0_ready  = grant0;
    bus.p1_ready  = grant1;
    bus.rsv_ready = rsv_ok;
    bus.q_busy1   = busy_at(busy_q, bus.q_a1);
    bus.q_busy2   = busy_at(busy_q, bus.q_a2);
    bus.we3       = we3_q;
    bus.a3        = a3_q;
    bus.wd3       = wd3_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Scoreboard bench for rf_write_arbiter: directed scenarios plus
//               randomized traffic against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  rf_write_arbiter #(.DATA_WIDTH(DW), .NREG(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          we;
    logic [4:0]  a;
    logic [31:0] d;
  } commit_t;

  commit_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit          m_busy[32];
  bit          m_last_p1;     // port 1 won the most recent grant
  int          m_clr;         // register to free at the next edge, -1 for none
  logic [4:0]  m_a3;
  logic [31:0] m_wd3;

  // Last observed handshake values, for the directed expectations
  bit s_p0r, s_p1r, s_rsvr, s_qb1, s_qb2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit m_busy_of(input logic [4:0] a);
    return (a != 5'd0) && m_busy[a];
  endfunction

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_last_p1 = 1'b1;
    m_clr     = -1;
    m_a3      = '0;
    m_wd3     = '0;
    exp_q.delete();
  endtask

  // One clock of stimulus: drive at the falling edge, check the combinational
  // responses against the model, queue the expected commit, advance the model.
  task automatic drive(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                       input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                       input bit rv, input logic [4:0] ra,
                       input logic [4:0] qa1, input logic [4:0] qa2);
    bit g0, g1, rr;
    commit_t e;
    @(negedge clk);
    bus.p0_valid = v0;  bus.p0_addr = a0;  bus.p0_data = d0;
    bus.p1_valid = v1;  bus.p1_addr = a1;  bus.p1_data = d1;
    bus.rsv_valid = rv; bus.rsv_addr = ra;
    bus.q_a1 = qa1;     bus.q_a2 = qa2;
    #1;
    // Port 0 waits on an owed register; if both can go, the one not served last wins.
    g0 = v0 && !m_busy_of(a0) && (!v1 || m_last_p1);
    g1 = v1 && !g0;
    rr = !m_busy_of(ra);
    s_p0r = bus.p0_ready; s_p1r = bus.p1_ready; s_rsvr = bus.rsv_ready;
    s_qb1 = bus.q_busy1;  s_qb2 = bus.q_busy2;
    chk("p0_ready",  32'(s_p0r),  32'(g0));
    chk("p1_ready",  32'(s_p1r),  32'(g1));
    chk("rsv_ready", 32'(s_rsvr), 32'(rr));
    chk("q_busy1",   32'(s_qb1),  32'(m_busy_of(qa1)));
    chk("q_busy2",   32'(s_qb2),  32'(m_busy_of(qa2)));
    if (g0) begin
      m_a3 = a0; m_wd3 = d0;
    end else if (g1) begin
      m_a3 = a1; m_wd3 = d1;
    end
    e.we = (g0 || g1) && (m_a3 != 5'd0);
    e.a  = m_a3;
    e.d  = m_wd3;
    exp_q.push_back(e);
    @(posedge clk);
    if (m_clr >= 0) m_busy[m_clr] = 1'b0;
    if (rv && rr && ra != 5'd0) m_busy[ra] = 1'b1;
    m_clr = g1 ? int'(a1) : -1;
    if (g0) m_last_p1 = 1'b0;
    if (g1) m_last_p1 = 1'b1;
  endtask

  task automatic idle(input logic [4:0] qa1);
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, qa1, 5'd0);
  endtask

  // Monitor: compare the registered write port with the queued expectation.
  always begin
    commit_t e;
    @(posedge clk);
    #1;
    if (rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("we3", 32'(bus.we3), 32'(e.we));
      chk("a3",  32'(bus.a3),  32'(e.a));
      chk("wd3", bus.wd3,      e.d);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          hold0, hold1;
    bit          v0, v1, rv;
    logic [4:0]  a0, a1, ra;
    logic [31:0] d0, d1;

    model_reset();
    // Reset with every request raised
    bus.p0_valid = 1; bus.p0_addr = 5'd1; bus.p0_data = 32'h11;
    bus.p1_valid = 1; bus.p1_addr = 5'd2; bus.p1_data = 32'h22;
    bus.rsv_valid = 1; bus.rsv_addr = 5'd3;
    bus.q_a1 = 5'd3; bus.q_a2 = 5'd1;
    #12;
    chk("rst_we3",       32'(bus.we3), 32'd0);
    chk("rst_a3",        32'(bus.a3),  32'd0);
    chk("rst_wd3",       bus.wd3,      32'd0);
    chk("rst_p0_ready",  32'(bus.p0_ready),  32'd0);
    chk("rst_p1_ready",  32'(bus.p1_ready),  32'd0);
    chk("rst_rsv_ready", 32'(bus.rsv_ready), 32'd0);
    chk("rst_q_busy1",   32'(bus.q_busy1),   32'd0);
    chk("rst_q_busy2",   32'(bus.q_busy2),   32'd0);
    @(negedge clk);
    bus.p0_valid = 0; bus.p1_valid = 0; bus.rsv_valid = 0;
    rst = 1'b1;

    // Contention: p0 first, then strict alternation
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'd1, 32'h100 + 32'(i), 1, 5'd2, 32'h200 + 32'(i), 0, 5'd0, 5'd0, 5'd0);
      chk("cont_p0_ready", 32'(s_p0r), 32'((i % 2) == 0));
      chk("cont_p1_ready", 32'(s_p1r), 32'((i % 2) == 1));
    end
    idle(5'd0);

    // Single port write
    drive(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0);
    chk("single_p0_ready", 32'(s_p0r), 32'd1);
    idle(5'd0);
    idle(5'd0);

    // Scoreboard: port 0 waits for the owed x7
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd7, 5'd7, 5'd0);
    chk("rsv7_ready", 32'(s_rsvr), 32'd1);
    drive(1, 5'd7, 32'hAAAA, 0, 5'd0, 32'd0, 0, 5'd0, 5'd7, 5'd0);
    chk("x7_p0_blocked", 32'(s_p0r), 32'd0);
    chk("x7_q_busy1",    32'(s_qb1), 32'd1);
    drive(1, 5'd7, 32'hAAAA, 1, 5'd7, 32'h55, 0, 5'd0, 5'd7, 5'd0);
    chk("x7_p1_granted", 32'(s_p1r), 32'd1);
    chk("x7_p0_still",   32'(s_p0r), 32'd0);
    drive(1, 5'd7, 32'hAAAA, 0, 5'd0, 32'd0, 0, 5'd0, 5'd7, 5'd0);
    chk("x7_n1_p0_ready", 32'(s_p0r), 32'd0);
    chk("x7_n1_q_busy1",  32'(s_qb1), 32'd1);
    drive(1, 5'd7, 32'hAAAA, 0, 5'd0, 32'd0, 0, 5'd0, 5'd7, 5'd0);
    chk("x7_n2_p0_ready", 32'(s_p0r), 32'd1);
    chk("x7_n2_q_busy1",  32'(s_qb1), 32'd0);
    idle(5'd0);

    // x0 write is accepted and dropped
    drive(1, 5'd0, 32'h1234, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0);
    chk("x0_p0_ready", 32'(s_p0r), 32'd1);
    idle(5'd0);

    // Double reservation of x9, then a same-edge set and clear
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd9, 5'd9, 5'd0);
    chk("rsv9_first", 32'(s_rsvr), 32'd1);
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd9, 5'd9, 5'd0);
    chk("rsv9_second", 32'(s_rsvr), 32'd0);
    drive(0, 5'd0, 32'd0, 1, 5'd9, 32'h99, 1, 5'd9, 5'd9, 5'd0);
    chk("rsv9_during_p1", 32'(s_rsvr), 32'd0);
    idle(5'd9);
    idle(5'd9);
    chk("x9_free", 32'(s_qb1), 32'd0);
    drive(0, 5'd0, 32'd0, 1, 5'd9, 32'h9A, 0, 5'd0, 5'd9, 5'd0);
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd9, 5'd9, 5'd0);
    chk("rsv9_reuse", 32'(s_rsvr), 32'd1);
    idle(5'd9);
    chk("x9_set_wins", 32'(s_qb1), 32'd1);
    drive(0, 5'd0, 32'd0, 1, 5'd9, 32'h9B, 0, 5'd0, 5'd9, 5'd0);
    idle(5'd9);
    idle(5'd9);

    // Reset in the middle of a port-1 write
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd3, 5'd3, 5'd0);
    drive(0, 5'd0, 32'd0, 1, 5'd4, 32'h4444, 0, 5'd0, 5'd3, 5'd0);
    chk("mid_p1_ready", 32'(s_p1r), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("mid_rst_we3",     32'(bus.we3),     32'd0);
    chk("mid_rst_q_busy1", 32'(bus.q_busy1), 32'd0);
    chk("mid_rst_p1_ready", 32'(bus.p1_ready), 32'd0);
    @(negedge clk);
    bus.p0_valid = 0; bus.p1_valid = 0; bus.rsv_valid = 0;
    model_reset();
    rst = 1'b1;
    idle(5'd3);
    chk("post_rst_x3_free", 32'(s_qb1), 32'd0);

    // Randomized traffic; a stalled requester keeps its request stable
    hold0 = 0; hold1 = 0;
    v0 = 0; v1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    for (int c = 0; c < 400; c++) begin
      if (!hold0) begin
        v0 = ($urandom_range(0, 3) != 0);
        a0 = 5'($urandom_range(0, 15));
        d0 = $urandom;
      end
      if (!hold1) begin
        v1 = ($urandom_range(0, 2) == 0);
        a1 = 5'($urandom_range(0, 15));
        d1 = $urandom;
      end
      rv = ($urandom_range(0, 3) == 0);
      ra = 5'($urandom_range(0, 15));
      drive(v0, a0, d0, v1, a1, d1, rv, ra,
            5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
      hold0 = v0 && !s_p0r;
      hold1 = v1 && !s_p1r;
    end
    idle(5'd0);
    idle(5'd0);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
